// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory-port responder backed by a word-addressed array.
// Define MEM_RESPONDER_WAIT_EN to add a read_latency-cycle read delay (R_WAIT state).
module mem_responder #(
  parameter int bus_width    = 32,
  parameter int depth        = 1024,
  parameter int read_latency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raddr_valid,
  output logic                 raddr_ready,
  input  logic [bus_width-1:0] raddr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [bus_width-1:0] rdata,
  input  logic                 waddr_valid,
  output logic                 waddr_ready,
  input  logic [bus_width-1:0] waddr,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [bus_width-1:0] wdata
);
  localparam int AW = $clog2(depth);

`ifdef MEM_RESPONDER_WAIT_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  localparam logic [3:0] LAT = 4'(read_latency);
`else
  typedef enum logic [1:0] {R_IDLE, R_RESP} r_state_t;
`endif

  logic [bus_width-1:0] mem [depth];

  r_state_t             r_state_q, r_state_d;
  logic [bus_width-1:0] rdata_q, rdata_d;
`ifdef MEM_RESPONDER_WAIT_EN
  logic [AW-1:0]        r_idx_q, r_idx_d;
  logic [3:0]           cnt_q, cnt_d;
`endif
  logic [AW-1:0]        wa_idx_q, wa_idx_d;
  logic [bus_width-1:0] wd_q, wd_d;
  logic                 wa_held_q, wa_held_d;
  logic                 wd_held_q, wd_held_d;

  logic                 r_accept, wa_hs, wd_hs, w_commit;
  logic [AW-1:0]        w_idx;
  logic [bus_width-1:0] w_data;

  assign rdata_valid = (r_state_q == R_RESP);
  assign rdata       = rdata_q;

  always_comb begin
    case (r_state_q)
      R_IDLE:  raddr_ready = 1'b1;
      R_RESP:  raddr_ready = rdata_ready;
      default: raddr_ready = 1'b0;
    endcase
  end

  assign r_accept = raddr_valid && raddr_ready;

  // A new accept overrides the return to idle when it coincides with the rdata handshake.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
`ifdef MEM_RESPONDER_WAIT_EN
    r_idx_d   = r_idx_q;
    cnt_d     = cnt_q;
`endif
    if (rdata_valid && rdata_ready) r_state_d = R_IDLE;
`ifdef MEM_RESPONDER_WAIT_EN
    if (r_state_q == R_WAIT) begin
      if (cnt_q == 4'd1) begin
        rdata_d   = mem[r_idx_q];
        r_state_d = R_RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
`endif
    if (r_accept) begin
`ifdef MEM_RESPONDER_WAIT_EN
      if (LAT > 4'd1) begin
        r_idx_d   = raddr[2 +: AW];
        cnt_d     = LAT - 4'd1;
        r_state_d = R_WAIT;
      end else begin
        rdata_d   = mem[raddr[2 +: AW]];
        r_state_d = R_RESP;
      end
`else
      rdata_d   = mem[raddr[2 +: AW]];
      r_state_d = R_RESP;
`endif
    end
  end

  assign waddr_ready = !wa_held_q;
  assign wdata_ready = !wd_held_q;
  assign wa_hs       = waddr_valid && !wa_held_q;
  assign wd_hs       = wdata_valid && !wd_held_q;
  assign w_commit    = (wa_held_q || wa_hs) && (wd_held_q || wd_hs);
  assign w_idx       = wa_held_q ? wa_idx_q : waddr[2 +: AW];
  assign w_data      = wd_held_q ? wd_q : wdata;

  always_comb begin
    wa_held_d = wa_held_q;
    wd_held_d = wd_held_q;
    wa_idx_d  = wa_idx_q;
    wd_d      = wd_q;
    if (w_commit) begin
      wa_held_d = 1'b0;
      wd_held_d = 1'b0;
    end else begin
      if (wa_hs) begin
        wa_held_d = 1'b1;
        wa_idx_d  = waddr[2 +: AW];
      end
      if (wd_hs) begin
        wd_held_d = 1'b1;
        wd_d      = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
`ifdef MEM_RESPONDER_WAIT_EN
      r_idx_q   <= '0;
      cnt_q     <= '0;
`endif
      wa_held_q <= 1'b0;
      wd_held_q <= 1'b0;
      wa_idx_q  <= '0;
      wd_q      <= '0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
`ifdef MEM_RESPONDER_WAIT_EN
      r_idx_q   <= r_idx_d;
      cnt_q     <= cnt_d;
`endif
      wa_held_q <= wa_held_d;
      wd_held_q <= wd_held_d;
      wa_idx_q  <= wa_idx_d;
      wd_q      <= wd_d;
    end
  end

  // Array has no reset; reads above sample it before this edge's write lands.
  always_ff @(posedge clk) begin
    if (w_commit) mem[w_idx] <= w_data;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[1:0], raddr[bus_width-1:AW+2],
                              waddr[1:0], waddr[bus_width-1:AW+2]};
`ifndef MEM_RESPONDER_WAIT_EN
  logic unused_latency;
  assign unused_latency = (read_latency != 1);
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against an array reference model of the word-addressed memory.
module tb_mem_responder;
  localparam int DEPTH = 1024;
`ifdef MEM_RESPONDER_WAIT_EN
  localparam int L = 4;
`else
  localparam int L = 1;
`endif

  logic        clk, rst;
  logic        raddr_valid, raddr_ready, rdata_valid, rdata_ready;
  logic [31:0] raddr, rdata;
  logic        waddr_valid, waddr_ready, wdata_valid, wdata_ready;
  logic [31:0] waddr, wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0]  model_mem [DEPTH];
  logic [31:0]  stream_addrs[$];
  int unsigned  pend[$];

  mem_responder #(.bus_width(32), .depth(DEPTH), .read_latency(L)) dut (
    .clk(clk), .rst(rst),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready), .raddr(raddr),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    check_output("rst_rvalid", rdata_valid, 0);
    check_output("rst_rdata", rdata, 0);
    check_output("rst_raddr_ready", raddr_ready, 1);
    check_output("rst_waddr_ready", waddr_ready, 1);
    check_output("rst_wdata_ready", wdata_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    waddr_valid = 1'b1; waddr = a;
    wdata_valid = 1'b1; wdata = d;
    check_output("wr_ready", {waddr_ready, wdata_ready}, 2'b11);
    step();
    waddr_valid = 1'b0; wdata_valid = 1'b0;
    model_mem[widx(a)] = d;
  endtask

  task automatic split_write(input logic [31:0] a, input logic [31:0] d,
                             input bit addr_first, input int gap);
    logic [1:0] held;
    held = addr_first ? 2'b01 : 2'b10;
    if (addr_first) begin waddr_valid = 1'b1; waddr = a; end
    else begin wdata_valid = 1'b1; wdata = d; end
    step();
    waddr_valid = 1'b0; wdata_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      check_output("split_held", {waddr_ready, wdata_ready}, held);
      step();
    end
    if (addr_first) begin wdata_valid = 1'b1; wdata = d; end
    else begin waddr_valid = 1'b1; waddr = a; end
    check_output("split_held_last", {waddr_ready, wdata_ready}, held);
    step();
    waddr_valid = 1'b0; wdata_valid = 1'b0;
    check_output("split_done", {waddr_ready, wdata_ready}, 2'b11);
    model_mem[widx(a)] = d;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    logic [31:0] expv;
    int n;
    expv = model_mem[widx(a)];
    raddr_valid = 1'b1; raddr = a; rdata_ready = 1'b1;
    check_output({tag, "_raddr_ready"}, raddr_ready, 1);
    step();
    raddr_valid = 1'b0;
    n = 1;
    while (!rdata_valid && n < 20) begin step(); n++; end
    check_output({tag, "_latency"}, n, L);
    check_output({tag, "_data"}, rdata, expv);
    step();
  endtask

  task automatic stream_reads();
    int issued, got, cyc, last, total;
    bit acc, beat;
    total = stream_addrs.size();
    issued = 0; got = 0; cyc = 0; last = -1;
    pend.delete();
    raddr_valid = 1'b1; raddr = stream_addrs[0]; rdata_ready = 1'b1;
    while (got < total && cyc < 300) begin
      acc  = raddr_valid && raddr_ready;
      beat = rdata_valid && rdata_ready;
      if (beat && pend.size() > 0) begin
        check_output("stream_data", rdata, model_mem[pend.pop_front()]);
        if (last >= 0) check_output("stream_spacing", cyc - last, L);
        last = cyc;
        got++;
      end
      if (acc) begin pend.push_back(widx(raddr)); issued++; end
      step();
      cyc++;
      if (acc) begin
        if (issued < total) raddr = stream_addrs[issued];
        else raddr_valid = 1'b0;
      end
    end
    raddr_valid = 1'b0;
    check_output("stream_count", got, total);
  endtask

  initial begin
    logic [31:0] old0, newv, d;
    int n;
    rst = 1'b1;
    raddr_valid = 1'b0; raddr = '0; rdata_ready = 1'b1;
    waddr_valid = 1'b0; waddr = '0; wdata_valid = 1'b0; wdata = '0;
    #1;
    apply_reset();

    // Fill every word through wrapped, misaligned addresses so the model is fully known.
    for (int i = 0; i < DEPTH; i++)
      do_write(($urandom() & ~32'hFFC) | (32'(i) << 2), $urandom());

    do_write(32'h10, 32'hDEADBEEF);
    do_read("wr_rd", 32'h10);

    split_write(32'h20, 32'h12345678, 1'b1, 2);
    do_read("split_rd", 32'h20);
    split_write(32'h24, 32'hCAFEF00D, 1'b0, 1);
    do_read("split_rev_rd", 32'h24);

    stream_addrs = '{32'h0, 32'h4, 32'h8};
    stream_reads();
    stream_addrs.delete();
    for (int i = 0; i < 8; i++) stream_addrs.push_back($urandom());
    stream_reads();

    // Backpressure: data held steady and no new accept while rdata_ready is low.
    rdata_ready = 1'b0; raddr_valid = 1'b1; raddr = 32'h8;
    step();
    raddr = 32'hC;
    n = 1;
    while (!rdata_valid && n < 20) begin step(); n++; end
    check_output("bp_latency", n, L);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_valid", rdata_valid, 1);
      check_output("bp_data", rdata, model_mem[2]);
      check_output("bp_raddr_ready", raddr_ready, 0);
      do_write(32'h100 + 32'(i) * 4, $urandom());
    end
    rdata_ready = 1'b1;
    #1;
    check_output("bp_release_ready", raddr_ready, 1);
    step();
    raddr_valid = 1'b0;
    n = 1;
    while (!rdata_valid && n < 20) begin step(); n++; end
    check_output("bp_next_data", rdata, model_mem[3]);
    step();

    // Wrap: byte address 0x1000 lands on word 0.
    do_write(32'h1000, 32'hA5A5_0001);
    do_read("wrap_rd", 32'h0);

    // Same-edge collision: read capture of word 0 coincides with a write to word 0.
    old0 = model_mem[0];
    newv = 32'h5A5A_0002;
    for (int j = 0; j < L; j++) begin
      raddr_valid = (j == 0); raddr = 32'h0; rdata_ready = 1'b1;
      if (j == L - 1) begin
        waddr_valid = 1'b1; waddr = 32'h2000; wdata_valid = 1'b1; wdata = newv;
      end
      step();
      waddr_valid = 1'b0; wdata_valid = 1'b0; raddr_valid = 1'b0;
    end
    check_output("coll_valid", rdata_valid, 1);
    check_output("coll_old_data", rdata, old0);
    model_mem[0] = newv;
    step();
    do_read("coll_after", 32'h0);

    // Reset mid-operation: pending read dropped, held write address discarded.
    raddr_valid = 1'b1; raddr = 32'h4; rdata_ready = 1'b1;
    waddr_valid = 1'b1; waddr = 32'h40;
    step();
    raddr_valid = 1'b0; waddr_valid = 1'b0;
    check_output("pre_rst_wa_held", waddr_ready, 0);
    apply_reset();
    repeat (L + 1) step();
    check_output("post_rst_rvalid", rdata_valid, 0);
    check_output("post_rst_raddr_ready", raddr_ready, 1);
    d = $urandom();
    wdata_valid = 1'b1; wdata = d;
    step();
    wdata_valid = 1'b0;
    check_output("post_rst_wd_held", {waddr_ready, wdata_ready}, 2'b10);
    waddr_valid = 1'b1; waddr = 32'h44;
    step();
    waddr_valid = 1'b0;
    model_mem[widx(32'h44)] = d;
    do_read("post_rst_rd40", 32'h40);
    do_read("post_rst_rd44", 32'h44);

    // Randomized mix of paired writes, split writes and reads.
    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       do_write($urandom(), $urandom());
        1:       split_write($urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        default: do_read("rand_rd", $urandom());
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
